shift_unit: RTL and testbench

SHIFT_UNIT -- requirements
Module: shift_unit

---
 rtl/shift_pkg.sv | 29 ++
 rtl/shift_step.sv | 26 ++
 rtl/shift_unit.sv | 99 +++++++++
 tb/tb_shift_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types for the shift unit: operation codes and controller states.
package shift_pkg;

  // Operation codes as presented by the control unit on the Funct bus.
  typedef enum logic [2:0] {
    FN_HOLD0 = 3'b000,
    FN_LOAD  = 3'b001,
    FN_SLL   = 3'b010,
    FN_SRL   = 3'b011,
    FN_SRA   = 3'b100,
    FN_ROR   = 3'b101,
    FN_ROL   = 3'b110,
    FN_HOLD7 = 3'b111
  } funct_e;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // True for the codes that capture new operands; both HOLD codes leave
  // the shift register untouched.
  function automatic logic isCaptureOp(input funct_e f);
    return (f != FN_HOLD0) && (f != FN_HOLD7);
  endfunction

endpackage

// File: rtl/shift_step.sv
// One-bit move of the data word according to the latched operation.
// Purely combinational; the register that holds the word lives in shift_unit.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  funct_e             i_op,
  input  logic [WIDTH-1:0]   i_data,
  output logic [WIDTH-1:0]   o_data
);

  // Select the single-position move; LOAD and HOLD pass the word through.
  always_comb begin
    o_data = i_data;
    case (i_op)
      FN_SLL:  o_data = {i_data[WIDTH-2:0], 1'b0};
      FN_SRL:  o_data = {1'b0, i_data[WIDTH-1:1]};
      FN_SRA:  o_data = {i_data[WIDTH-1], i_data[WIDTH-1:1]};
      FN_ROR:  o_data = {i_data[0], i_data[WIDTH-1:1]};
      FN_ROL:  o_data = {i_data[WIDTH-2:0], i_data[WIDTH-1]};
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle shift unit: captures an operand, shift amount and operation
// on Start, moves the word one bit per clock, then pulses Done for a cycle.
module shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [2:0]         Funct,
  input  logic [CNT_W-1:0]   N,
  input  logic [WIDTH-1:0]   DataIn,
  output logic [WIDTH-1:0]   DataOut,
  output logic               Busy,
  output logic               Done
);

  state_e             r_state;
  state_e             w_stateNext;
  logic [WIDTH-1:0]   r_data;
  logic [WIDTH-1:0]   w_dataNext;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_countNext;
  funct_e             r_op;
  funct_e             w_opNext;
  funct_e             w_functIn;
  logic [WIDTH-1:0]   w_stepped;

  assign w_functIn = funct_e'(Funct);

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_op   (r_op),
    .i_data (r_data),
    .o_data (w_stepped)
  );

  // State, data, counter and op registers; reset clears everything at once.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_data  <= '0;
      r_count <= '0;
      r_op    <= FN_HOLD0;
    end else begin
      r_state <= w_stateNext;
      r_data  <= w_dataNext;
      r_count <= w_countNext;
      r_op    <= w_opNext;
    end
  end

  // Next-state and datapath updates; inputs only matter in IDLE with Start.
  always_comb begin
    w_stateNext = r_state;
    w_dataNext  = r_data;
    w_countNext = r_count;
    w_opNext    = r_op;
    case (r_state)
      ST_IDLE: begin
        if (Start) begin
          if (isCaptureOp(w_functIn)) begin
            w_dataNext  = DataIn;
            w_countNext = N;
            w_opNext    = w_functIn;
            if ((N == '0) || (w_functIn == FN_LOAD)) begin
              w_stateNext = ST_DONE;
            end else begin
              w_stateNext = ST_SHIFT;
            end
          end else begin
            w_stateNext = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        w_dataNext  = w_stepped;
        w_countNext = r_count - CNT_W'(1);
        if (r_count == CNT_W'(1)) begin
          w_stateNext = ST_DONE;
        end
      end
      ST_DONE: begin
        w_stateNext = ST_IDLE;
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  assign DataOut = r_data;
  assign Busy    = (r_state == ST_SHIFT) || (r_state == ST_DONE);
  assign Done    = (r_state == ST_DONE);

endmodule

// File: tb/tb_shift_unit.sv
// Randomized self-checking bench for shift_unit with a behavioural model.
module tb_shift_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  funct;
  logic [4:0]  n;
  logic [31:0] dataIn;
  logic [31:0] dataOut;
  logic        busy;
  logic        done;

  int          checkCount;
  int          errorCount;
  logic [31:0] prevData;

  shift_unit #(
    .WIDTH (32),
    .CNT_W (5)
  ) dut (
    .Clk     (clk),
    .Reset   (reset),
    .Start   (start),
    .Funct   (funct),
    .N       (n),
    .DataIn  (dataIn),
    .DataOut (dataOut),
    .Busy    (busy),
    .Done    (done)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point; every check is counted here.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Final result of an operation computed with whole-word arithmetic.
  function automatic logic [31:0] refResult(input logic [2:0] f, input logic [4:0] amt,
                                            input logic [31:0] din, input logic [31:0] prev);
    logic [63:0] twice;
    twice = {din, din};
    case (f)
      3'b001:  return din;
      3'b010:  return din << amt;
      3'b011:  return din >> amt;
      3'b100:  return 32'($signed(din) >>> amt);
      3'b101:  return 32'(twice >> amt);
      3'b110:  begin
        twice = twice << amt;
        return twice[63:32];
      end
      default: return prev;
    endcase
  endfunction

  // Clock edges after the capture edge until Done is visible: one per shifted
  // bit, none when nothing has to move.
  function automatic int refLatency(input logic [2:0] f, input logic [4:0] amt);
    if (f == 3'b000 || f == 3'b111 || f == 3'b001 || amt == 5'd0) return 0;
    return int'(amt);
  endfunction

  // Runs one operation starting at a negedge in IDLE and returns at the
  // negedge of the following IDLE cycle, so calls chain back-to-back.
  task automatic applyStimulus(input logic [2:0] f, input logic [4:0] amt,
                               input logic [31:0] din, input bit perturb);
    logic [31:0] expData;
    int          expLat;
    int          edges;
    expData = refResult(f, amt, din, prevData);
    expLat  = refLatency(f, amt);
    start   = 1'b1;
    funct   = f;
    n       = amt;
    dataIn  = din;
    @(posedge clk);
    @(negedge clk);
    edges = 0;
    start = perturb ? 1'b1 : 1'b0;
    if (perturb) begin
      funct  = 3'($urandom);
      n      = 5'($urandom);
      dataIn = $urandom;
    end
    while (done !== 1'b1 && edges < 40) begin
      checkOutput("busy_mid", {31'd0, busy}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      edges++;
      if (perturb) begin
        start  = 1'($urandom);
        funct  = 3'($urandom);
        n      = 5'($urandom);
        dataIn = $urandom;
      end
    end
    checkOutput("latency", 32'(edges), 32'(expLat));
    checkOutput("result", dataOut, expData);
    checkOutput("busy_done", {31'd0, busy}, 32'd1);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("done_once", {31'd0, done}, 32'd0);
    checkOutput("busy_idle", {31'd0, busy}, 32'd0);
    checkOutput("hold_idle", dataOut, expData);
    prevData = expData;
  endtask

  // Aborts an SLL N=10 in its third cycle and confirms no Done follows.
  task automatic resetMidShift();
    int pulses;
    start  = 1'b1;
    funct  = 3'b010;
    n      = 5'd10;
    dataIn = 32'h0000_0001;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("rst_data", dataOut, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    checkOutput("rst_no_done", 32'(pulses), 32'd0);
    checkOutput("rst_data_after", dataOut, 32'd0);
    prevData = 32'd0;
  endtask

  initial begin
    logic [2:0]  rf;
    logic [4:0]  rn;
    logic [31:0] rd;
    checkCount = 0;
    errorCount = 0;
    prevData   = 32'd0;
    reset      = 1'b0;
    start      = 1'b0;
    funct      = 3'b000;
    n          = 5'd0;
    dataIn     = 32'd0;
    #1 reset = 1'b1;
    #2;
    checkOutput("reset_data", dataOut, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] directed operations");
    applyStimulus(3'b010, 5'd4,  32'h0000_0001, 1'b0);
    applyStimulus(3'b100, 5'd31, 32'h8000_0000, 1'b0);
    applyStimulus(3'b011, 5'd31, 32'h8000_0000, 1'b0);
    applyStimulus(3'b101, 5'd1,  32'h0000_0001, 1'b0);
    applyStimulus(3'b110, 5'd1,  32'h8000_0000, 1'b0);
    applyStimulus(3'b010, 5'd0,  32'h1234_5678, 1'b0);
    applyStimulus(3'b001, 5'd7,  32'hDEAD_BEEF, 1'b0);
    applyStimulus(3'b000, 5'd3,  32'hFFFF_0000, 1'b0);
    applyStimulus(3'b111, 5'd9,  32'h0F0F_0F0F, 1'b0);
    applyStimulus(3'b010, 5'd10, 32'h0000_0003, 1'b1);
    applyStimulus(3'b100, 5'd17, 32'hC001_D00D, 1'b1);

    $display("[TB] reset during shift");
    resetMidShift();
    applyStimulus(3'b110, 5'd5, 32'h8000_0001, 1'b0);

    $display("[TB] random operations");
    for (int i = 0; i < 200; i++) begin
      rf = 3'($urandom);
      rn = 5'($urandom);
      rd = $urandom;
      applyStimulus(rf, rn, rd, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
